lsu_mem_ctrl: RTL and testbench
===============================

LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_W, default 8: width of the response watchdog counter.
REQ-002 SHALL have port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_ni, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have the pipeline-side inputs req_valid_i (1), req_we_i (1, 1=store), funct3_i (3), addr_i (32), wdata_i (32) and flush_i (1).
REQ-005 SHALL have the pipeline-side outputs stall_o (1), rdata_o (32), rdata_valid_o (1), misaligned_o (1) and bus_err_o (1).
REQ-006 SHALL have the memory-side outputs mem_req_o (1), mem_we_o (1), mem_addr_o (32, word-aligned), mem_be_o (4) and mem_wdata_o (32).
REQ-007 SHALL have the memory-side inputs mem_gnt_i (1), mem_rvalid_i (1) and mem_rdata_i (32).

Function
REQ-008 SHALL implement FSM states IDLE, REQ, WAIT and DONE.
REQ-009 SHALL decode funct3_i as 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU; other load codes SHALL act as LW and other store codes as SW.
REQ-010 SHALL flag a request as misaligned when it is a halfword with addr_i[0]=1 or a word with addr_i[1:0]!=00.
REQ-011 In IDLE, with req_valid_i=1, flush_i=0 and the request misaligned: SHALL pulse misaligned_o for that cycle (combinational), issue no memory request and hold stall_o=0.
REQ-012 In IDLE, with req_valid_i=1, flush_i=0 and the request aligned: SHALL drive stall_o=1 combinationally, register the address, type and store data, and enter REQ.
REQ-013 In REQ: SHALL hold mem_req_o=1 with mem_we_o, mem_addr_o={addr[31:2],00}, mem_be_o and mem_wdata_o stable until mem_gnt_i=1, then enter WAIT.
REQ-014 Byte enables: SB = 0001<<addr[1:0]; SH = 0011<<{addr[1],0}; SW = 1111.
REQ-015 Store data: SB replicates byte [7:0] into all four lanes; SH replicates halfword [15:0] into both halves; SW passes the word unchanged.
REQ-016 In WAIT: SHALL ignore mem_gnt_i; on mem_rvalid_i=1, SHALL shift mem_rdata_i right by addr[1:0]*8, sign-extend (LB/LH) or zero-extend (LBU/LHU), register the result into rdata_o and enter DONE.
REQ-017 SHALL treat a store as complete on mem_rvalid_i, leaving rdata_o unchanged for stores.
REQ-018 mem_rvalid_i outside WAIT SHALL be ignored.
REQ-019 In DONE: SHALL drive stall_o=0 and rdata_valid_o=1 (loads only) for exactly one cycle, ignore req_valid_i and return to IDLE.
REQ-020 Minimum latency with gnt and rvalid immediate SHALL be 4 cycles (IDLE, REQ, WAIT, DONE); stall_o SHALL be 1 in IDLE-accept, REQ and WAIT.
REQ-021 Flush in REQ without mem_gnt_i SHALL drop the request and return to IDLE on the next cycle; flush with mem_gnt_i in the same cycle SHALL be treated as granted.
REQ-022 Flush in WAIT or DONE SHALL let the access complete and SHALL suppress rdata_valid_o.

Reset
REQ-023 On rst_ni=0 the FSM SHALL be forced to IDLE immediately; all outputs SHALL be 0, including rdata_o and mem_addr_o, and the timeout counter SHALL be 0.
REQ-024 Reset asserted mid-access SHALL abandon the access, and a late mem_rvalid_i after reset SHALL be ignored per REQ-018.

Configuration
REQ-025 With LSU_TIMEOUT_EN defined: a counter SHALL run in REQ and WAIT; on reaching 2^TIMEOUT_W-1 it SHALL pulse bus_err_o for one cycle, drop mem_req_o and enter DONE with rdata_valid_o=0.
REQ-026 Without LSU_TIMEOUT_EN: no counter SHALL exist, bus_err_o SHALL be tied to 0 and REQ/WAIT SHALL wait indefinitely.

Verification
REQ-027 LB at addr 0x1003, mem_rdata_i=0x80FF_1234, gnt and rvalid immediate -> mem_be_o=1000, rdata_o=0xFFFF_FF80, rdata_valid_o high in cycle 4.
REQ-028 SH at addr 0x2002, wdata_i=0x0000_ABCD, gnt delayed 3 cycles -> mem_req_o held 4 cycles, mem_be_o=1100, mem_wdata_o=0xABCD_ABCD, stall_o high throughout.
REQ-029 LW at addr 0x0006 -> misaligned_o=1 for one cycle, mem_req_o=0, stall_o=0.
REQ-030 LHU at addr 0x0002, flush_i in WAIT, rvalid data 0x8001_0000 -> returns to IDLE, rdata_valid_o stays 0.
REQ-031 Load with mem_gnt_i tied 0: with LSU_TIMEOUT_EN and TIMEOUT_W=4 -> bus_err_o pulses at 15 cycles; without the macro -> stall_o stays 1.
REQ-032 rst_ni pulsed low while in WAIT -> FSM returns to IDLE, outputs 0, and a following rvalid produces no rdata_valid_o.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_mem_ctrl
//
// Load/store unit memory controller. Takes one load or store from the pipeline
// at a time, checks alignment, formats byte enables and store data, runs the
// request/grant/response handshake with memory and returns extended load data.
//
// Optional feature (compile-time macro): LSU_TIMEOUT_EN
//   When defined, a response watchdog of TIMEOUT_W bits runs while the access is
//   in REQ or WAIT. On expiry, bus_err_o pulses for one cycle, the memory request
//   is dropped and the access finishes without returning load data.
//   When undefined, there is no watchdog and bus_err_o is tied to 0.
//
// Handshake semantics: mem_req_o stays high with address/enables/data stable
// until a cycle in which mem_gnt_i is high; that cycle is the transfer. After
// the grant, exactly one mem_rvalid_i pulse completes the access (for a store
// it is the write acknowledge). mem_rvalid_i is ignored in every other state.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req_valid_i            pipeline presents an access this cycle
//   req_we_i               1 = store, 0 = load
//   funct3_i[2:0]          access size / signedness
//   addr_i[31:0]           byte address
//   wdata_i[31:0]          store data (right-aligned)
//   flush_i                pipeline flush
//   stall_o                hold the pipeline while an access is in flight
//   rdata_o[31:0]          extended load result (registered)
//   rdata_valid_o          one-cycle pulse when rdata_o holds a new load result
//   misaligned_o           one-cycle pulse: request rejected as misaligned
//   bus_err_o              one-cycle pulse: watchdog expired
//   mem_req_o, mem_we_o    memory request / write
//   mem_addr_o[31:0]       word-aligned address
//   mem_be_o[3:0]          byte enables
//   mem_wdata_o[31:0]      lane-replicated store data
//   mem_gnt_i              memory accepted the request
//   mem_rvalid_i           memory response / write acknowledge
//   mem_rdata_i[31:0]      memory read data
// -----------------------------------------------------------------------------
module lsu_mem_ctrl #(
    parameter int TIMEOUT_W = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    input  logic        req_we_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    output logic        misaligned_o,
    output logic        bus_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    // Set when the pipeline flushed after the access was committed to memory;
    // the access still completes but its load result is not reported.
    logic        kill_q, kill_d;

    logic        req_byte, req_half, req_word, req_mis;
    logic        accept, mis_pulse;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [31:0] shifted;
    logic [31:0] load_data;
    logic        tmo_fire;
    logic        mem_req;

    // ---------------------------------------------------------------------
    // Request decode. Unknown load codes behave as LW and unknown store codes
    // (including 100/101, which only exist as loads) behave as SW.
    // ---------------------------------------------------------------------
    always_comb begin
        req_byte = (funct3_i == 3'b000) || (!req_we_i && (funct3_i == 3'b100));
        req_half = (funct3_i == 3'b001) || (!req_we_i && (funct3_i == 3'b101));
        req_word = !req_byte && !req_half;
        req_mis  = (req_half && addr_i[0]) || (req_word && (addr_i[1:0] != 2'b00));
    end

    // rst_ni is folded in so the combinational outputs read 0 during reset
    // even if the pipeline is already presenting a request.
    assign mis_pulse = rst_ni && (state_q == ST_IDLE) && req_valid_i && !flush_i && req_mis;
    assign accept    = rst_ni && (state_q == ST_IDLE) && req_valid_i && !flush_i && !req_mis;

    // Byte enables and lane-replicated store data, captured at accept.
    always_comb begin
        be_new    = 4'b1111;
        wdata_new = wdata_i;
        if (req_byte) begin
            be_new    = 4'b0001 << addr_i[1:0];
            wdata_new = {4{wdata_i[7:0]}};
        end else if (req_half) begin
            be_new    = 4'b0011 << {addr_i[1], 1'b0};
            wdata_new = {2{wdata_i[15:0]}};
        end
    end

    // Load data: bring the addressed byte/halfword down to bit 0, then extend.
    always_comb begin
        shifted = mem_rdata_i >> {addr_q[1:0], 3'b000};
        case (f3_q)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_data = {24'd0, shifted[7:0]};
            3'b101:  load_data = {16'd0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    // ---------------------------------------------------------------------
    // Response watchdog
    // ---------------------------------------------------------------------
`ifdef LSU_TIMEOUT_EN
    // cnt_q counts completed REQ/WAIT cycles of the current access, so
    // cnt_q + 1 is the index of the current cycle. The watchdog fires in the
    // cycle where that index reaches 2^TIMEOUT_W-1.
    localparam logic [TIMEOUT_W-1:0] CNT_LAST = ~TIMEOUT_W'(1);

    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                 busy;

    assign busy = (state_q == ST_REQ) || (state_q == ST_WAIT);

    always_comb begin
        cnt_d = '0;
        if (busy) begin
            cnt_d = cnt_q + TIMEOUT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A response arriving in the expiry cycle still wins.
    assign tmo_fire  = busy && (cnt_q == CNT_LAST) &&
                       !((state_q == ST_WAIT) && mem_rvalid_i);
    assign bus_err_o = tmo_fire;
`else
    assign tmo_fire  = 1'b0;
    assign bus_err_o = 1'b0;
`endif

    // ---------------------------------------------------------------------
    // FSM: next state and outputs
    // ---------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        we_d          = we_q;
        f3_d          = f3_q;
        be_d          = be_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        kill_d        = kill_q;
        stall_o       = 1'b0;
        misaligned_o  = 1'b0;
        rdata_valid_o = 1'b0;
        mem_req       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                kill_d       = 1'b0;
                misaligned_o = mis_pulse;
                if (accept) begin
                    stall_o = 1'b1;
                    addr_d  = addr_i;
                    we_d    = req_we_i;
                    f3_d    = funct3_i;
                    be_d    = be_new;
                    wdata_d = wdata_new;
                    state_d = ST_REQ;
                end
            end

            ST_REQ: begin
                stall_o = 1'b1;
                if (tmo_fire) begin
                    kill_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    mem_req = 1'b1;
                    if (mem_gnt_i) begin
                        // Once granted, memory owns the access: it must finish.
                        if (flush_i) begin
                            kill_d = 1'b1;
                        end
                        state_d = ST_WAIT;
                    end else if (flush_i) begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_WAIT: begin
                stall_o = 1'b1;
                if (flush_i) begin
                    kill_d = 1'b1;
                end
                if (mem_rvalid_i) begin
                    if (!we_q) begin
                        rdata_d = load_data;
                    end
                    state_d = ST_DONE;
                end else if (tmo_fire) begin
                    kill_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                rdata_valid_o = !we_q && !kill_q && !flush_i;
                state_d       = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            kill_q  <= kill_d;
        end
    end

    // Memory-side fields are only driven while a request is on the bus.
    assign mem_req_o   = mem_req;
    assign mem_we_o    = mem_req && we_q;
    assign mem_addr_o  = mem_req ? {addr_q[31:2], 2'b00} : 32'd0;
    assign mem_be_o    = mem_req ? be_q : 4'd0;
    assign mem_wdata_o = mem_req ? wdata_q : 32'd0;
    assign rdata_o     = rdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_mem_ctrl
//
// Bench for lsu_mem_ctrl: table of single accesses plus hand-written
// sequences for flush, reset-in-flight and the stuck-grant case. Expected load
// results are queued when a load is accepted and compared when rdata_valid_o
// is seen.
// -----------------------------------------------------------------------------
module tb_lsu_mem_ctrl;

    localparam int TW = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_we_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        flush_i;
    logic        stall_o;
    logic [31:0] rdata_o;
    logic        rdata_valid_o;
    logic        misaligned_o;
    logic        bus_err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    lsu_mem_ctrl #(.TIMEOUT_W(TW)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_valid_i   (req_valid_i),
        .req_we_i      (req_we_i),
        .funct3_i      (funct3_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .flush_i       (flush_i),
        .stall_o       (stall_o),
        .rdata_o       (rdata_o),
        .rdata_valid_o (rdata_valid_o),
        .misaligned_o  (misaligned_o),
        .bus_err_o     (bus_err_o),
        .mem_req_o     (mem_req_o),
        .mem_we_o      (mem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_be_o      (mem_be_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i)
    );

    // ---------------- clock ----------------
    always #5 clk_i = ~clk_i;

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    logic [31:0] last_rdata;
    int          n_cmp  = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive point: 1 ns after the rising edge. Sample point: falling edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gnt_dly;
        int          rv_dly;
        logic        mis;
        logic [3:0]  be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                input int gnt_dly, input int rv_dly, input logic mis,
                                input logic [3:0] be, input logic [31:0] exp_wdata,
                                input logic [31:0] exp_rdata);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.gnt_dly = gnt_dly; v.rv_dly = rv_dly; v.mis = mis; v.be = be;
        v.exp_wdata = exp_wdata; v.exp_rdata = exp_rdata;
        return v;
    endfunction

    // ---------------- driver: one complete access ----------------
    task automatic run_access(input vec_t v);
        logic [31:0] exp_word;
        tick();
        req_valid_i = 1'b1;
        req_we_i    = v.we;
        funct3_i    = v.f3;
        addr_i      = v.addr;
        wdata_i     = v.wdata;
        @(negedge clk_i);
        check("accept_misaligned", misaligned_o, v.mis);
        check("accept_stall", stall_o, !v.mis);
        check("accept_mem_req", mem_req_o, 1'b0);
        tick();
        req_valid_i = 1'b0;
        if (v.mis) begin
            @(negedge clk_i);
            check("mis_no_req", mem_req_o, 1'b0);
            check("mis_pulse_end", misaligned_o, 1'b0);
            return;
        end
        if (!v.we) exp_q.push_back(v.exp_rdata);
        // REQ phase; junk responses before the grant must be ignored
        for (int i = 0; i <= v.gnt_dly; i++) begin
            mem_gnt_i    = (i == v.gnt_dly);
            mem_rvalid_i = (i == v.gnt_dly) ? 1'b0 : 1'($urandom_range(0, 1));
            mem_rdata_i  = $urandom;
            @(negedge clk_i);
            check("req_mem_req", mem_req_o, 1'b1);
            check("req_we", mem_we_o, v.we);
            check("req_addr", mem_addr_o, v.addr & 32'hFFFF_FFFC);
            check("req_be", mem_be_o, v.be);
            check("req_stall", stall_o, 1'b1);
            if (v.we) check("req_wdata", mem_wdata_o, v.exp_wdata);
            tick();
        end
        mem_gnt_i = 1'b0;
        // WAIT phase
        for (int i = 0; i <= v.rv_dly; i++) begin
            mem_rvalid_i = (i == v.rv_dly);
            mem_rdata_i  = (i == v.rv_dly) ? v.rdata : $urandom;
            @(negedge clk_i);
            check("wait_stall", stall_o, 1'b1);
            check("wait_mem_req", mem_req_o, 1'b0);
            tick();
        end
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = $urandom;
        // DONE
        @(negedge clk_i);
        check("done_stall", stall_o, 1'b0);
        check("done_rdata_valid", rdata_valid_o, !v.we);
        if (rdata_valid_o) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_rdata_valid: got 0x%08h expected no result", rdata_o);
            end else begin
                exp_word = exp_q.pop_front();
                check("rdata", rdata_o, exp_word);
                last_rdata = exp_word;
            end
        end else if (v.we) begin
            check("store_keeps_rdata", rdata_o, last_rdata);
        end
        tick();
        @(negedge clk_i);
        check("idle_stall", stall_o, 1'b0);
        check("idle_rdata_valid", rdata_valid_o, 1'b0);
    endtask

    vec_t vecs[16];
    int   hit;

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    // ---------------- main ----------------
    initial begin
        vecs[0]  = mk(1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0, 0, 1'b0, 4'b1000, 32'h0, 32'hFFFF_FF80);
        vecs[1]  = mk(1'b1, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 32'h0, 3, 0, 1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0);
        vecs[2]  = mk(1'b0, 3'b010, 32'h0000_0006, 32'h0, 32'h0, 0, 0, 1'b1, 4'b0000, 32'h0, 32'h0);
        vecs[3]  = mk(1'b1, 3'b000, 32'h0000_0101, 32'h1234_5677, 32'h0, 0, 1, 1'b0, 4'b0010, 32'h7777_7777, 32'h0);
        vecs[4]  = mk(1'b1, 3'b010, 32'h0000_0008, 32'hDEAD_BEEF, 32'h0, 1, 2, 1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h0);
        vecs[5]  = mk(1'b0, 3'b001, 32'h0000_0002, 32'h0, 32'h8001_0000, 0, 0, 1'b0, 4'b1100, 32'h0, 32'hFFFF_8001);
        vecs[6]  = mk(1'b0, 3'b101, 32'h0000_0002, 32'h0, 32'h8001_0000, 0, 0, 1'b0, 4'b1100, 32'h0, 32'h0000_8001);
        vecs[7]  = mk(1'b0, 3'b100, 32'h0000_0001, 32'h0, 32'h0000_F500, 0, 0, 1'b0, 4'b0010, 32'h0, 32'h0000_00F5);
        vecs[8]  = mk(1'b0, 3'b010, 32'h0000_0010, 32'h0, 32'h1122_3344, 2, 1, 1'b0, 4'b1111, 32'h0, 32'h1122_3344);
        vecs[9]  = mk(1'b1, 3'b001, 32'h0000_0001, 32'h0, 32'h0, 0, 0, 1'b1, 4'b0000, 32'h0, 32'h0);
        vecs[10] = mk(1'b0, 3'b001, 32'h0000_0003, 32'h0, 32'h0, 0, 0, 1'b1, 4'b0000, 32'h0, 32'h0);
        vecs[11] = mk(1'b0, 3'b011, 32'h0000_0004, 32'h0, 32'hCAFE_F00D, 0, 0, 1'b0, 4'b1111, 32'h0, 32'hCAFE_F00D);
        vecs[12] = mk(1'b1, 3'b100, 32'h0000_0002, 32'h0, 32'h0, 0, 0, 1'b1, 4'b0000, 32'h0, 32'h0);
        vecs[13] = mk(1'b0, 3'b000, 32'h0000_0000, 32'h0, 32'h0000_007F, 0, 0, 1'b0, 4'b0001, 32'h0, 32'h0000_007F);
        vecs[14] = mk(1'b1, 3'b000, 32'h0000_0003, 32'h0000_00A5, 32'h0, 0, 0, 1'b0, 4'b1000, 32'hA5A5_A5A5, 32'h0);
        vecs[15] = mk(1'b0, 3'b100, 32'h0000_0002, 32'h0, 32'h00C3_0000, 0, 1, 1'b0, 4'b0100, 32'h0, 32'h0000_00C3);

        // ---- reset: outputs 0 even with a request presented ----
        rst_ni       = 1'b0;
        req_valid_i  = 1'b1;
        req_we_i     = 1'b0;
        funct3_i     = 3'b010;
        addr_i       = 32'h0000_0100;
        wdata_i      = 32'h0;
        flush_i      = 1'b0;
        mem_gnt_i    = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hFFFF_FFFF;
        last_rdata   = 32'h0;
        #3;
        check("rst_stall", stall_o, 1'b0);
        check("rst_misaligned", misaligned_o, 1'b0);
        repeat (2) tick();
        check("rst_mem_req", mem_req_o, 1'b0);
        check("rst_mem_addr", mem_addr_o, 32'h0);
        check("rst_rdata", rdata_o, 32'h0);
        check("rst_rdata_valid", rdata_valid_o, 1'b0);
        check("rst_bus_err", bus_err_o, 1'b0);
        req_valid_i  = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;

        // ---- table-driven single accesses ----
        for (int k = 0; k < 16; k++) run_access(vecs[k]);

        // ---- flush in WAIT: access completes, no rdata_valid ----
        tick();
        req_valid_i = 1'b1; req_we_i = 1'b0; funct3_i = 3'b101; addr_i = 32'h0000_0002;
        tick();
        req_valid_i = 1'b0; mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0; flush_i = 1'b1;
        @(negedge clk_i);
        check("fw_wait_stall", stall_o, 1'b1);
        tick();
        flush_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h8001_0000;
        tick();
        mem_rvalid_i = 1'b0;
        @(negedge clk_i);
        check("fw_done_stall", stall_o, 1'b0);
        check("fw_no_rdata_valid", rdata_valid_o, 1'b0);
        tick();
        @(negedge clk_i);
        check("fw_idle_stall", stall_o, 1'b0);
        check("fw_idle_req", mem_req_o, 1'b0);

        // ---- flush in REQ without grant: dropped, late rvalid ignored ----
        tick();
        req_valid_i = 1'b1; req_we_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h0000_0020;
        tick();
        req_valid_i = 1'b0; mem_gnt_i = 1'b0; flush_i = 1'b1;
        @(negedge clk_i);
        check("fr_req_still_up", mem_req_o, 1'b1);
        tick();
        flush_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5555_AAAA;
        @(negedge clk_i);
        check("fr_dropped_req", mem_req_o, 1'b0);
        check("fr_dropped_stall", stall_o, 1'b0);
        tick();
        mem_rvalid_i = 1'b0;
        @(negedge clk_i);
        check("fr_no_rdata_valid", rdata_valid_o, 1'b0);
        check("fr_no_stall", stall_o, 1'b0);

        // ---- flush with grant: treated as granted; DONE ignores req_valid ----
        tick();
        req_valid_i = 1'b1; req_we_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h0000_0030;
        wdata_i = 32'h0BAD_F00D;
        tick();
        req_valid_i = 1'b0; mem_gnt_i = 1'b1; flush_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0; flush_i = 1'b0;
        @(negedge clk_i);
        check("fg_wait_stall", stall_o, 1'b1);
        check("fg_wait_req", mem_req_o, 1'b0);
        tick();
        mem_rvalid_i = 1'b1;
        tick();
        mem_rvalid_i = 1'b0;
        req_valid_i = 1'b1; req_we_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h0000_0000;
        @(negedge clk_i);
        check("fg_done_stall", stall_o, 1'b0);
        check("fg_done_rdata_valid", rdata_valid_o, 1'b0);
        tick();
        req_valid_i = 1'b0;
        @(negedge clk_i);
        check("done_ignores_req", mem_req_o, 1'b0);
        check("done_ignores_stall", stall_o, 1'b0);

        // ---- reset while in WAIT ----
        tick();
        req_valid_i = 1'b1; req_we_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h0000_0040;
        tick();
        req_valid_i = 1'b0; mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        @(negedge clk_i);
        check("rw_wait_stall", stall_o, 1'b1);
        rst_ni = 1'b0;
        #1;
        check("rw_stall", stall_o, 1'b0);
        check("rw_mem_req", mem_req_o, 1'b0);
        check("rw_rdata", rdata_o, 32'h0);
        check("rw_rdata_valid", rdata_valid_o, 1'b0);
        #2;
        rst_ni = 1'b1;
        last_rdata = 32'h0;
        tick();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234_5678;
        @(negedge clk_i);
        check("rw_late_rvalid_stall", stall_o, 1'b0);
        tick();
        mem_rvalid_i = 1'b0;
        @(negedge clk_i);
        check("rw_late_no_valid", rdata_valid_o, 1'b0);
        check("rw_late_rdata", rdata_o, 32'h0);

        // ---- grant never arrives ----
        tick();
        req_valid_i = 1'b1; req_we_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h0000_0080;
        tick();
        req_valid_i = 1'b0; mem_gnt_i = 1'b0;
`ifdef LSU_TIMEOUT_EN
        hit = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk_i);
            if (bus_err_o && hit == 0) hit = c;
            tick();
            if (hit != 0) break;
        end
        check("tmo_cycle", hit, 15);
        @(negedge clk_i);
        check("tmo_done_stall", stall_o, 1'b0);
        check("tmo_no_rdata_valid", rdata_valid_o, 1'b0);
        check("tmo_err_single", bus_err_o, 1'b0);
        tick();
`else
        hit = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk_i);
            check("hang_stall", stall_o, 1'b1);
            check("hang_mem_req", mem_req_o, 1'b1);
            check("hang_bus_err", bus_err_o, 1'b0);
            tick();
        end
        exp_q.push_back(32'h5A5A_0F0F);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5A5A_0F0F;
        tick();
        mem_rvalid_i = 1'b0;
        @(negedge clk_i);
        check("hang_done_valid", rdata_valid_o, 1'b1);
        if (rdata_valid_o && exp_q.size() != 0) check("hang_rdata", rdata_o, exp_q.pop_front());
        tick();
`endif

        check("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
